// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
// Shares one single-port 32-bit on-chip RAM between two requesters.
// The two requesters are named m0 and m1.
//
// Arbitration:
//   - At most one command is forwarded per cycle.
//   - When both requesters ask in the same cycle, the one that did not win
//     last time is granted (strict round-robin).
//   - After reset, m0 wins the first contention.
//
// Out-of-range commands (address >= DEPTH):
//   - They are accepted, but they never reach the RAM.
//   - Each one increments the saturating err_count.
//   - A read of this kind returns zero data.
//
// Read data returns with a fixed latency of one cycle. A registered stage
// remembers the read's owner and its range flag until the data comes back.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   mN_address/byteenable/read/write/writedata   requester N command
//   mN_waitrequest               requester N must hold its command
//   mN_readdata/readdatavalid    requester N read return
//   mem_address/byteenable/writedata/chipselect/write   RAM command
//   mem_readdata                 RAM data, valid the cycle after its address
//   err_count                    saturating out-of-range access count
module onchip_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 51200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m0_byteenable,
  input  logic [3:0]        m1_byteenable,
  input  logic              m0_read,
  input  logic              m1_read,
  input  logic              m0_write,
  input  logic              m1_write,
  input  logic [31:0]       m0_writedata,
  input  logic [31:0]       m1_writedata,
  output logic              m0_waitrequest,
  output logic              m1_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic [31:0]       m1_readdata,
  output logic              m0_readdatavalid,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  input  logic [31:0]       mem_readdata,
  output logic [15:0]       err_count
);

  // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic              req0, req1;
  logic              gnt_vld, gnt_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata;
  logic              sel_write, sel_inrange;
  logic [31:0]       ret_data;

  logic              last_grant_q, last_grant_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_owner_q, rd_owner_d;
  logic              rd_inr_q, rd_inr_d;
  logic [15:0]       err_q, err_d;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (reset) begin
      gnt_vld = 1'b0;
      gnt_idx = 1'b0;
    end else begin
      case ({req1, req0})
        2'b01:   begin gnt_vld = 1'b1; gnt_idx = 1'b0;          end
        2'b10:   begin gnt_vld = 1'b1; gnt_idx = 1'b1;          end
        2'b11:   begin gnt_vld = 1'b1; gnt_idx = ~last_grant_q; end
        default: begin gnt_vld = 1'b0; gnt_idx = 1'b0;          end
      endcase
    end
  end

  // Mux the granted requester's command; write dominates read.
  always_comb begin
    sel_addr  = '0;
    sel_be    = 4'h0;
    sel_wdata = 32'h0;
    sel_write = 1'b0;
    if (gnt_idx) begin
      sel_addr  = m1_address;
      sel_be    = m1_byteenable;
      sel_wdata = m1_writedata;
      sel_write = m1_write;
    end else begin
      sel_addr  = m0_address;
      sel_be    = m0_byteenable;
      sel_wdata = m0_writedata;
      sel_write = m0_write;
    end
    sel_inrange = ({1'b0, sel_addr} < DEPTH_W);
  end

  // RAM command and waitrequest generation.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = 4'h0;
    mem_writedata  = 32'h0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (gnt_vld) begin
      mem_address    = sel_addr;
      mem_byteenable = sel_be;
      mem_writedata  = sel_wdata;
      // An out-of-range command is accepted but never reaches the RAM.
      mem_chipselect = sel_inrange;
      mem_write      = sel_inrange & sel_write;
    end else begin
      mem_address    = '0;
      mem_byteenable = 4'h0;
      mem_writedata  = 32'h0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
    end
    // A requester must hold its command whenever it is asking but was not
    // granted; an idle requester sees waitrequest=0.
    m0_waitrequest = reset | (req0 & ~(gnt_vld & ~gnt_idx));
    m1_waitrequest = reset | (req1 & ~(gnt_vld &  gnt_idx));
  end

  // Next state: round-robin pointer, read return stage, error counter.
  always_comb begin
    last_grant_d = last_grant_q;
    rd_vld_d     = gnt_vld & ~sel_write;
    rd_owner_d   = gnt_idx;
    rd_inr_d     = sel_inrange;
    err_d        = err_q;
    if (gnt_vld) begin
      last_grant_d = gnt_idx;
    end else begin
      last_grant_d = last_grant_q;
    end
    if (gnt_vld && !sel_inrange && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers; last_grant resets to 1 so that m0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_vld_q     <= 1'b0;
      rd_owner_q   <= 1'b0;
      rd_inr_q     <= 1'b0;
      err_q        <= 16'h0000;
    end else begin
      last_grant_q <= last_grant_d;
      rd_vld_q     <= rd_vld_d;
      rd_owner_q   <= rd_owner_d;
      rd_inr_q     <= rd_inr_d;
      err_q        <= err_d;
    end
  end

  // Read return steering; data is forced to zero unless qualified.
  always_comb begin
    m0_readdatavalid = rd_vld_q & ~rd_owner_q;
    m1_readdatavalid = rd_vld_q &  rd_owner_q;
    ret_data         = 32'h0;
    if (rd_inr_q) begin
      ret_data = mem_readdata;
    end else begin
      ret_data = 32'h0;
    end
    m0_readdata = m0_readdatavalid ? ret_data : 32'h0;
    m1_readdata = m1_readdatavalid ? ret_data : 32'h0;
  end

  assign err_count = err_q;

endmodule
